sram_2r1w_param: RTL and testbench

- Parametrised 1-write/2-read synchronous SRAM model; next generation of the fixed 240-bit × 200-entry instruction store.
- Adds per-port read enables and read-valid flags, registered one-cycle reads, and out-of-range address detection.
- Adds a hardware init sequencer that fills the array after reset or on request, so fetch logic sees deterministic contents.
- Sits between the fetch stage (two read ports) and the instruction loader (write port).

---
 rtl/sram_pkg.sv | 20 ++
 rtl/sram_read_port.sv | 59 +++++
 rtl/sram_2r1w_param.sv | 125 ++++++++++++
 tb/tb_sram_2r1w_param.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the 2-read/1-write instruction store:
// FSM state encoding, default geometry and the address range helper.
package sram_pkg;

  localparam int DEFAULT_DATA_W = 240;
  localparam int DEFAULT_DEPTH  = 200;
  localparam int DEFAULT_ADDR_W = 8;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sramStateT;

  // True when the address selects a real entry (addresses at or above
  // depth exist on the bus but have no storage behind them).
  function automatic logic addrInRange(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/sram_read_port.sv
// One registered read port of the instruction store: range check,
// optional write-first bypass, one-cycle read latency and valid flag.
// Configuration macro: SRAM_WR_BYPASS_EN (defined = write-first,
// undefined = read-first).
module sram_read_port
  import sram_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              accessEn,
  input  logic              readEnable,
  input  logic [ADDR_W-1:0] readAddress,
  input  logic [DATA_W-1:0] memData,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] writeBus,
  output logic [DATA_W-1:0] readBus,
  output logic              readValid,
  output logic              rangeErr
);

  logic              inRange;
  logic              doRead;
  logic [DATA_W-1:0] readData;

  assign inRange  = addrInRange(32'(readAddress), DEPTH);
  assign doRead   = accessEn & readEnable;
  assign rangeErr = doRead & ~inRange;

`ifdef SRAM_WR_BYPASS_EN
  // A write landing on the same entry this cycle wins over the stored word.
  logic bypassHit;
  assign bypassHit = writeEnable & (writeAddress == readAddress) & inRange;
  assign readData  = bypassHit ? writeBus : memData;
`else
  // Read-first: the array value sampled before the write edge is returned.
  logic unusedBypassInputs;
  assign unusedBypassInputs = ^{writeEnable, writeAddress, writeBus};
  assign readData = memData;
`endif

  // Capture read data and valid; an idle port holds its last data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readBus   <= '0;
      readValid <= 1'b0;
    end else begin
      readValid <= doRead;
      if (doRead) begin
        readBus <= inRange ? readData : '0;
      end
    end
  end

endmodule

// File: rtl/sram_2r1w_param.sv
// Parametrised 1-write/2-read synchronous SRAM with an init sequencer
// that fills every entry with INIT_VALUE after reset or on clear.
// Configuration macro: SRAM_WR_BYPASS_EN selects write-first behaviour
// for a same-cycle read and write of one address (see sram_read_port).
module sram_2r1w_param
  import sram_pkg::*;
#(
  parameter int                DATA_W     = DEFAULT_DATA_W,
  parameter int                DEPTH      = DEFAULT_DEPTH,
  parameter int                ADDR_W     = DEFAULT_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  output logic              ready,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic [DATA_W-1:0] WriteBus,
  input  logic              RE1,
  input  logic              RE2,
  input  logic [ADDR_W-1:0] ReadAddress1,
  input  logic [ADDR_W-1:0] ReadAddress2,
  output logic [DATA_W-1:0] ReadBus1,
  output logic [DATA_W-1:0] ReadBus2,
  output logic              ReadValid1,
  output logic              ReadValid2,
  output logic              AddrErr
);

  localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

  sramStateT         state;
  logic [ADDR_W-1:0] initCount;
  logic [DATA_W-1:0] memArray [DEPTH];

  logic              accessEn;
  logic              initWrite;
  logic              writeInRange;
  logic              userWrite;
  logic              writeErr;

  logic              portRe    [2];
  logic [ADDR_W-1:0] portAddr  [2];
  logic [DATA_W-1:0] portBus   [2];
  logic              portValid [2];
  logic              portErr   [2];

  // External accesses only count in RUN, and a clear cycle swallows them.
  assign accessEn     = (state == ST_RUN) & ~clear;
  assign ready        = (state == ST_RUN);
  // reset_n gates the fill so edges seen while held in reset write nothing.
  assign initWrite    = (state == ST_INIT) & reset_n;
  assign writeInRange = addrInRange(32'(WriteAddress), DEPTH);
  assign userWrite    = accessEn & WE & writeInRange;
  assign writeErr     = accessEn & WE & ~writeInRange;

  // Sequence INIT -> RUN; clear restarts the fill from entry 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      initCount <= '0;
    end else if (clear) begin
      state     <= ST_INIT;
      initCount <= '0;
    end else if (state == ST_INIT) begin
      if (initCount == LAST_ENTRY) begin
        state     <= ST_RUN;
        initCount <= '0;
      end else begin
        initCount <= initCount + 1'b1;
      end
    end
  end

  // Array write: fill value during INIT, loader data during RUN.
  always_ff @(posedge clock) begin
    if (initWrite) begin
      memArray[initCount] <= INIT_VALUE;
    end else if (userWrite) begin
      memArray[WriteAddress] <= WriteBus;
    end
  end

  assign portRe[0]   = RE1;
  assign portRe[1]   = RE2;
  assign portAddr[0] = ReadAddress1;
  assign portAddr[1] = ReadAddress2;

  for (genvar gi = 0; gi < 2; gi++) begin : gReadPort
    sram_read_port #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) uReadPort (
      .clock        (clock),
      .reset_n      (reset_n),
      .accessEn     (accessEn),
      .readEnable   (portRe[gi]),
      .readAddress  (portAddr[gi]),
      .memData      (memArray[portAddr[gi]]),
      .writeEnable  (userWrite),
      .writeAddress (WriteAddress),
      .writeBus     (WriteBus),
      .readBus      (portBus[gi]),
      .readValid    (portValid[gi]),
      .rangeErr     (portErr[gi])
    );
  end

  assign ReadBus1   = portBus[0];
  assign ReadBus2   = portBus[1];
  assign ReadValid1 = portValid[0];
  assign ReadValid2 = portValid[1];

  // Any out-of-range access in a cycle yields one pulse, aligned with read data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      AddrErr <= 1'b0;
    end else begin
      AddrErr <= writeErr | portErr[0] | portErr[1];
    end
  end

endmodule

// File: tb/tb_sram_2r1w_param.sv
// Directed bench for sram_2r1w_param at default geometry (240 x 200).
module tb_sram_2r1w_param;

  localparam int DW    = 240;
  localparam int DEPTH = 200;
  localparam int AW    = 8;

  localparam logic [DW-1:0] PAT_A5 = {30{8'hA5}};
  localparam logic [DW-1:0] ONES   = {DW{1'b1}};
  localparam logic [DW-1:0] ONE    = DW'(1);
`ifdef SRAM_WR_BYPASS_EN
  localparam logic [DW-1:0] SAME_CYCLE_EXP = ONE;
`else
  localparam logic [DW-1:0] SAME_CYCLE_EXP = '0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          clear;
  logic          ready;
  logic          WE;
  logic [AW-1:0] WriteAddress;
  logic [DW-1:0] WriteBus;
  logic          RE1, RE2;
  logic [AW-1:0] ReadAddress1, ReadAddress2;
  logic [DW-1:0] ReadBus1, ReadBus2;
  logic          ReadValid1, ReadValid2;
  logic          AddrErr;

  int checks = 0;
  int errors = 0;

  sram_2r1w_param #(
    .DATA_W     (DW),
    .DEPTH      (DEPTH),
    .ADDR_W     (AW),
    .INIT_VALUE ('0)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (clear),
    .ready        (ready),
    .WE           (WE),
    .WriteAddress (WriteAddress),
    .WriteBus     (WriteBus),
    .RE1          (RE1),
    .RE2          (RE2),
    .ReadAddress1 (ReadAddress1),
    .ReadAddress2 (ReadAddress2),
    .ReadBus1     (ReadBus1),
    .ReadBus2     (ReadBus2),
    .ReadValid1   (ReadValid1),
    .ReadValid2   (ReadValid2),
    .AddrErr      (AddrErr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    WE    = 1'b0;
    RE1   = 1'b0;
    RE2   = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    WriteAddress = '0;
    WriteBus     = '0;
    ReadAddress1 = '0;
    ReadAddress2 = '0;
    #2;
    chk("rst_ready", ready, 0);
    chk("rst_bus1", ReadBus1, 0);
    chk("rst_valid1", ReadValid1, 0);
    chk("rst_valid2", ReadValid2, 0);
    chk("rst_addrerr", AddrErr, 0);
    tick();
    tick();
    reset_n = 1'b1;

    // INIT: 200 cycles of ready=0; a read at cycle 5 is ignored
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 6) begin
        chk("init_read_ignored", ReadValid1, 0);
        RE1 = 1'b0;
      end
      chk("init_ready_low", ready, 0);
      if (i == 5) begin
        RE1 = 1'b1;
        ReadAddress1 = 8'd0;
      end
      tick();
    end
    chk("init_ready_high", ready, 1);

    // Boundary entries hold INIT_VALUE
    RE1 = 1'b1; ReadAddress1 = 8'd0;
    RE2 = 1'b1; ReadAddress2 = 8'd199;
    tick();
    idle();
    chk("rd0_bus", ReadBus1, 0);
    chk("rd0_valid", ReadValid1, 1);
    chk("rd199_bus", ReadBus2, 0);
    chk("rd199_valid", ReadValid2, 1);
    chk("rd199_addrerr", AddrErr, 0);
    tick();
    chk("idle_valid1", ReadValid1, 0);

    // Write A5 pattern to 17, read on both ports next cycle
    WE = 1'b1; WriteAddress = 8'd17; WriteBus = PAT_A5;
    tick();
    idle();
    RE1 = 1'b1; ReadAddress1 = 8'd17;
    RE2 = 1'b1; ReadAddress2 = 8'd17;
    tick();
    idle();
    chk("a5_bus1", ReadBus1, PAT_A5);
    chk("a5_bus2", ReadBus2, PAT_A5);
    chk("a5_valid1", ReadValid1, 1);
    chk("a5_valid2", ReadValid2, 1);
    tick();
    chk("a5_hold_bus1", ReadBus1, PAT_A5);
    chk("a5_idle_valid2", ReadValid2, 0);

    // Same-cycle write and read of address 5
    WE = 1'b1; WriteAddress = 8'd5; WriteBus = ONE;
    RE1 = 1'b1; ReadAddress1 = 8'd5;
    tick();
    idle();
    chk("samecyc_bus1", ReadBus1, SAME_CYCLE_EXP);
    chk("samecyc_valid1", ReadValid1, 1);
    chk("samecyc_hold_bus2", ReadBus2, PAT_A5);
    RE1 = 1'b1; ReadAddress1 = 8'd5;
    tick();
    idle();
    chk("after_write_bus1", ReadBus1, ONE);

    // Out of range: write to 200 dropped, read of 255 gives zero with valid
    WE = 1'b1; WriteAddress = 8'd200; WriteBus = ONES;
    RE2 = 1'b1; ReadAddress2 = 8'd255;
    tick();
    idle();
    chk("oor_bus2", ReadBus2, 0);
    chk("oor_valid2", ReadValid2, 1);
    chk("oor_addrerr", AddrErr, 1);
    chk("oor_valid1", ReadValid1, 0);
    tick();
    chk("oor_addrerr_pulse", AddrErr, 0);

    // Write-only out-of-range access also flags
    WE = 1'b1; WriteAddress = 8'd200; WriteBus = ONES;
    tick();
    idle();
    chk("oor_wr_addrerr", AddrErr, 1);

    // Three errors in one cycle -> one single-cycle pulse
    WE = 1'b1; WriteAddress = 8'd250; WriteBus = ONES;
    RE1 = 1'b1; ReadAddress1 = 8'd201;
    RE2 = 1'b1; ReadAddress2 = 8'd255;
    tick();
    idle();
    chk("multi_addrerr", AddrErr, 1);
    chk("multi_bus1", ReadBus1, 0);
    tick();
    chk("multi_addrerr_pulse", AddrErr, 0);

    // Neighbouring entries untouched by the dropped writes
    RE1 = 1'b1; ReadAddress1 = 8'd199;
    RE2 = 1'b1; ReadAddress2 = 8'd17;
    tick();
    idle();
    chk("oor_nochange_199", ReadBus1, 0);
    chk("oor_nochange_17", ReadBus2, PAT_A5);

    // Clear with a same-cycle read; then a write at INIT cycle 10 is ignored
    WE = 1'b1; WriteAddress = 8'd3; WriteBus = ONES;
    tick();
    idle();
    clear = 1'b1;
    RE1 = 1'b1; ReadAddress1 = 8'd3;
    tick();
    idle();
    chk("clear_ready", ready, 0);
    chk("clear_read_ignored", ReadValid1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("clr_init_ready_low", ready, 0);
      if (i == 10) begin
        WE = 1'b1; WriteAddress = 8'd3; WriteBus = ONES;
      end
      if (i == 11) idle();
      tick();
    end
    chk("clr_init_ready_high", ready, 1);
    RE1 = 1'b1; ReadAddress1 = 8'd3;
    RE2 = 1'b1; ReadAddress2 = 8'd17;
    tick();
    idle();
    chk("clr_entry3", ReadBus1, 0);
    chk("clr_entry17", ReadBus2, 0);
    RE1 = 1'b1; ReadAddress1 = 8'd5;
    tick();
    idle();
    chk("clr_entry5", ReadBus1, 0);

    // Reset mid-INIT at counter 57
    WE = 1'b1; WriteAddress = 8'd17; WriteBus = PAT_A5;
    tick();
    idle();
    RE1 = 1'b1; ReadAddress1 = 8'd17;
    tick();
    idle();
    chk("pre_rst_bus1", ReadBus1, PAT_A5);
    clear = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 57; i++) tick();
    chk("mid_init_ready", ready, 0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_ready", ready, 0);
    chk("async_rst_bus1", ReadBus1, 0);
    chk("async_rst_valid1", ReadValid1, 0);
    chk("async_rst_addrerr", AddrErr, 0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("rerst_ready_low", ready, 0);
      tick();
    end
    chk("rerst_ready_high", ready, 1);
    RE1 = 1'b1; ReadAddress1 = 8'd17;
    RE2 = 1'b1; ReadAddress2 = 8'd199;
    tick();
    idle();
    chk("rerst_entry17", ReadBus1, 0);
    chk("rerst_valid2", ReadValid2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
